// File: rtl/btn_action_repeater_pkg.sv
// Shared definitions for the button action repeater: channel state encoding
// and default timing constants for a 50 MHz clock.
package btn_action_repeater_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HELD   = 2'd3
    } chan_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYC = 500000;    // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY = 15000000;  // 300 ms
    localparam int unsigned DEF_REPEAT_RATE  = 5000000;   // 100 ms

endpackage

// File: rtl/btn_action_repeater_channel.sv
// One button: 2-flop synchroniser, debounce counter and press/auto-repeat FSM.
// raw_pulse lags the debounced level rise by one cycle (registered FSM output).
module btn_channel
    import btn_action_repeater_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic raw_pulse
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_END    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] DELAY_END = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_END  = TMR_W'(REPEAT_RATE - 1);

    logic            sync1;
    logic            sbtn;
    logic [DB_W-1:0] cnt;

    // Level only moves after DEBOUNCE_CYC consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sbtn  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sbtn  <= sync1;
            if (sbtn != level) begin
                if (cnt == DB_END) begin
                    level <= sbtn;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    chan_state_t      state, state_nx;
    logic [TMR_W-1:0] tmr, tmr_nx;
    logic             pulse_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            raw_pulse <= 1'b0;
        end else begin
            state     <= state_nx;
            tmr       <= tmr_nx;
            raw_pulse <= pulse_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        pulse_nx = 1'b0;
        case (state)
            IDLE: begin
                if (level) begin
                    pulse_nx = 1'b1;
                    state_nx = DELAY;
                    tmr_nx   = '0;
                end
            end
            DELAY: begin
                if (!level) begin
                    state_nx = IDLE;
                    tmr_nx   = '0;
                end else if (tmr == DELAY_END) begin
                    tmr_nx = '0;
                    if (REPEAT_EN) begin
                        pulse_nx = 1'b1;
                        state_nx = REPEAT;
                    end else begin
                        state_nx = HELD;
                    end
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            REPEAT: begin
                if (!level) begin
                    state_nx = IDLE;
                    tmr_nx   = '0;
                end else if (tmr == RATE_END) begin
                    pulse_nx = 1'b1;
                    tmr_nx   = '0;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            HELD: begin
                if (!level) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/btn_action_repeater.sv
// Debounced, auto-repeating button actions plus a chord detector whose pulse
// doubles as reset_game; chord members are silenced until the chord is fully released.
module btn_action_repeater
    import btn_action_repeater_pkg::*;
#(
    parameter int unsigned        NUM_BTN      = 4,
    parameter int unsigned        DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned        REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned        REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK  = NUM_BTN'(3),
    parameter logic [NUM_BTN-1:0] COMBO_MASK   = NUM_BTN'(3)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] action,
    output logic               combo
);

    logic [NUM_BTN-1:0] raw_pulse;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_MASK[gi])
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw       (btn_raw[gi]),
            .level     (btn_level[gi]),
            .raw_pulse (raw_pulse[gi])
        );
    end

    logic combo_lock;
    logic chord_full;
    logic chord_none;

    assign chord_full = ((btn_level & COMBO_MASK) == COMBO_MASK);
    assign chord_none = ((btn_level & COMBO_MASK) == '0);

    // combo and lock register on the same edge as a member's press pulse,
    // so a chord-completing press is masked in the cycle it would appear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            combo      <= 1'b0;
            combo_lock <= 1'b0;
        end else begin
            combo <= chord_full && !combo_lock;
            if (chord_full && !combo_lock) combo_lock <= 1'b1;
            else if (chord_none)           combo_lock <= 1'b0;
        end
    end

    assign action = raw_pulse & ~(combo_lock ? COMBO_MASK : '0);

endmodule

// File: tb/tb_btn_action_repeater.sv
// Scoreboard bench: each scenario queues the pulses it expects (cycle, source);
// a negedge monitor logs every observed pulse and the two lists are compared.
module tb_btn_action_repeater;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam int SRC_COMBO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] action;
    logic          combo;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int exp_q[$];
    int obs_q[$];

    btn_action_repeater #(
        .NUM_BTN      (NB),
        .DEBOUNCE_CYC (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .REPEAT_MASK  (4'b0011),
        .COMBO_MASK   (4'b0011)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .action    (action),
        .combo     (combo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // event key = cycle*8 + source (0..3 action bits, 4 combo)
    always @(negedge clk) begin
        for (int i = 0; i < NB; i++)
            if (action[i]) obs_q.push_back(cyc * 8 + i);
        if (combo) obs_q.push_back(cyc * 8 + SRC_COMBO);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Held repeating button pressed at 'start', released at 'rel' (raw-level cycles).
    task automatic push_hold(input int src, input int start, input int rel);
        exp_q.push_back((start + DB + 3) * 8 + src);
        for (int c = start + DB + 3 + RD; c <= rel + DB + 2; c += RR)
            exp_q.push_back(c * 8 + src);
    endtask

    task automatic check_events(input string name);
        int e, o;
        @(posedge clk);
        #1;
        exp_q.sort();
        obs_q.sort();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s: missing pulse, got none, expected cyc=%0d src=%0d", name, e / 8, e % 8);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL %s: got pulse cyc=%0d src=%0d, expected cyc=%0d src=%0d",
                             name, o / 8, o % 8, e / 8, e % 8);
                end
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: unexpected pulse cyc=%0d src=%0d, expected none", name, o / 8, o % 8);
        end
    endtask

    task automatic test_reset();
        tick(3);
        vectors++;
        if (btn_level !== 4'b0) begin
            miscompares++; $display("FAIL reset_level: got %b expected 0000", btn_level);
        end
        vectors++;
        if (action !== 4'b0) begin
            miscompares++; $display("FAIL reset_action: got %b expected 0000", action);
        end
        vectors++;
        if (combo !== 1'b0) begin
            miscompares++; $display("FAIL reset_combo: got %b expected 0", combo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        check_events("reset_idle");
    endtask

    task automatic test_bounce();
        int last;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            btn_raw[2] = ((k / 2) % 2 == 0);
        end
        @(negedge clk);
        btn_raw[2] = 1'b1;
        last = cyc;
        exp_q.push_back((last + DB + 3) * 8 + 2);
        tick(60);
        vectors++;
        if (btn_level[2] !== 1'b1) begin
            miscompares++; $display("FAIL bounce_level: got %b expected 1", btn_level[2]);
        end
        btn_raw[2] = 1'b0;
        tick(12);
        check_events("bounce");
    endtask

    task automatic test_repeat();
        int s, rel;
        @(negedge clk);
        btn_raw[0] = 1'b1;
        s = cyc;
        tick(40);
        btn_raw[0] = 1'b0;
        rel = cyc;
        push_hold(0, s, rel);
        tick(DB + 1);
        vectors++;
        if (btn_level[0] !== 1'b1) begin
            miscompares++; $display("FAIL release_level_hold: got %b expected 1", btn_level[0]);
        end
        tick(1);
        vectors++;
        if (btn_level[0] !== 1'b0) begin
            miscompares++; $display("FAIL release_level_fall: got %b expected 0", btn_level[0]);
        end
        tick(10);
        check_events("repeat");
    endtask

    task automatic test_combo_seq();
        int s0, s1, s;
        @(negedge clk);
        btn_raw[0] = 1'b1;
        s0 = cyc;
        tick(2);
        btn_raw[1] = 1'b1;
        s1 = cyc;
        exp_q.push_back((s0 + DB + 3) * 8 + 0);
        exp_q.push_back((s1 + DB + 3) * 8 + SRC_COMBO);
        tick(50);
        btn_raw[1:0] = 2'b00;
        tick(15);
        check_events("combo_seq");
        @(negedge clk);
        btn_raw[1] = 1'b1;
        s = cyc;
        tick(8);
        btn_raw[1] = 1'b0;
        exp_q.push_back((s + DB + 3) * 8 + 1);
        tick(12);
        check_events("after_combo");
    endtask

    task automatic test_back_to_back();
        int s;
        @(negedge clk);
        btn_raw[1:0] = 2'b11;
        s = cyc;
        exp_q.push_back((s + DB + 3) * 8 + SRC_COMBO);
        tick(30);
        btn_raw[1:0] = 2'b00;
        tick(15);
        check_events("simultaneous");
    endtask

    task automatic test_reset_mid();
        int s, a, q, rel;
        @(negedge clk);
        btn_raw[0] = 1'b1;
        s = cyc;
        tick(25);
        rst_n = 1'b0;
        a = cyc;
        exp_q.push_back((s + DB + 3) * 8 + 0);
        for (int c = s + DB + 3 + RD; c <= a; c += RR)
            exp_q.push_back(c * 8 + 0);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            vectors++;
            if ({btn_level, action, combo} !== 9'b0) begin
                miscompares++;
                $display("FAIL in_reset: got level=%b action=%b combo=%b expected all 0",
                         btn_level, action, combo);
            end
        end
        rst_n = 1'b1;
        q = cyc;
        tick(21);
        btn_raw[0] = 1'b0;
        rel = cyc;
        push_hold(0, q, rel);
        tick(12);
        check_events("reset_mid");
    endtask

    task automatic test_all_bounce();
        int f[NB];
        int s;
        f[0] = 8; f[1] = 12; f[2] = 10; f[3] = 14;
        s = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 0) s = cyc;
            for (int i = 0; i < NB; i++) begin
                if (k >= f[i])          btn_raw[i] = 1'b1;
                else if (k == f[i] - 1) btn_raw[i] = 1'b0;
                else                    btn_raw[i] = ((k + i) % 3 == 0);
            end
        end
        exp_q.push_back((s + f[0] + DB + 3) * 8 + 0);
        exp_q.push_back((s + f[2] + DB + 3) * 8 + 2);
        exp_q.push_back((s + f[3] + DB + 3) * 8 + 3);
        exp_q.push_back((s + f[1] + DB + 3) * 8 + SRC_COMBO);
        @(negedge clk);
        btn_raw = '0;
        tick(20);
        check_events("all_bounce");
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_repeat();
        test_combo_seq();
        test_back_to_back();
        test_reset_mid();
        test_all_bounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
